mm_batch_control: RTL and testbench

//  Batch sequencer for the Montgomery multiplier top level. It is the parametrised successor of the single-shot top control.
//  It loads a shared key (p_prime_0, p) once, then runs up to SLOTS independent a*b products back-to-back through the FIOS core.
//  It writes each s-word result into that slot's result region of the bridge BRAM.
//  The key load is skipped when reuse_key_i is set and a key is already valid.

---
 rtl/mm_batch_control_if.sv | 11 +
 rtl/mm_batch_control.sv | 231 +++++++++++++++++++++++
 tb/tb_mm_batch_control.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_batch_control_if.sv
// BRAM port bundle between the batch sequencer (master) and the bridge BRAM (slave).
interface mm_batch_control_if #(
    parameter int AW = 32
);
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;

    modport master (output bram_en, bram_we, bram_addr);
    modport slave  (input  bram_en, bram_we, bram_addr);
endinterface

// File: rtl/mm_batch_control.sv
// Batch sequencer for the Montgomery multiplier: one key load, then up to SLOTS
// back-to-back FIOS products with results written to per-slot BRAM regions.
//  state    | meaning
//  IDLE     | waiting for start_i
//  LOAD_KEY | read p_prime_0 and p (s+1 reads, 2-cycle drain)
//  LOAD_OPS | read a then b of the current slot (2s reads, 2-cycle drain)
//  RUN      | one-cycle FIOS start
//  WAIT     | waiting for fios_done_i
//  STORE    | s result writes
//  NEXT     | advance slot or finish
//  DONE     | normal end pulse
//  ERR      | bad slot count or abort
module mm_batch_control #(
    parameter int W     = 17,
    parameter int s     = 8,
    parameter int SLOTS = 4,
    parameter int AW    = 32
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [$clog2(SLOTS+1)-1:0] slot_count_i,
    input  logic                       reuse_key_i,
    input  logic                       abort_i,
    input  logic                       fios_done_i,
    output logic                       pp0_en_o,
    output logic                       p_en_o,
    output logic                       a_en_o,
    output logic                       b_en_o,
    output logic                       fios_start_o,
    mm_batch_control_if.master         bram,
    output logic [$clog2(SLOTS)-1:0]   slot_o,
    output logic                       key_valid_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);
    localparam int CW = $clog2(SLOTS + 1);
    localparam int SW = $clog2(SLOTS);
    localparam int NW = $clog2(2 * s + 2);

    if (W < 1 || s < 2 || SLOTS < 2) begin : g_param_check
        $error("mm_batch_control: unsupported parameter set");
    end

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD_KEY, ST_LOAD_OPS, ST_RUN, ST_WAIT,
        ST_STORE, ST_NEXT, ST_DONE, ST_ERR
    } state_t;

    state_t        r_state, w_next;
    logic [NW-1:0] r_cnt, w_cnt_next;
    logic [SW-1:0] r_slot, w_slot_next;
    logic [CW-1:0] r_count, w_count_next;
    logic          r_key_valid, w_key_clr, w_key_set;
    logic [3:0]    r_ld0, r_ld1, r_ld_o, w_ld;
    logic          r_en, r_we, w_rd, w_wr;
    logic [AW-1:0] r_addr, w_addr, w_base;
    logic          r_fstart, w_fstart;
    logic          r_done, r_err, w_done, w_err;
    logic          w_abort;

    assign w_base = AW'(1 + s) + AW'(3 * s) * AW'(r_slot);

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_slot_next  = r_slot;
        w_count_next = r_count;
        w_key_clr    = 1'b0;
        w_key_set    = 1'b0;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_ld         = 4'b0000;
        w_addr       = '0;
        w_fstart     = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_abort      = abort_i && (r_state != ST_IDLE) &&
                       (r_state != ST_DONE) && (r_state != ST_ERR);
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (start_i) begin
                    if (slot_count_i == '0 || slot_count_i > CW'(SLOTS)) begin
                        w_next = ST_ERR;
                    end else begin
                        w_count_next = slot_count_i;
                        if (reuse_key_i && r_key_valid) begin
                            w_next = ST_LOAD_OPS;
                        end else begin
                            w_next    = ST_LOAD_KEY;
                            w_key_clr = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD_KEY: begin
                if (r_cnt <= NW'(s)) begin
                    w_rd   = 1'b1;
                    w_addr = AW'(r_cnt);
                    w_ld   = (r_cnt == '0) ? 4'b1000 : 4'b0100;
                end
                if (r_cnt == NW'(s + 2)) begin
                    w_next     = ST_LOAD_OPS;
                    w_cnt_next = '0;
                    w_key_set  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + NW'(1);
                end
            end
            ST_LOAD_OPS: begin
                if (r_cnt < NW'(2 * s)) begin
                    w_rd   = 1'b1;
                    w_addr = w_base + AW'(r_cnt);
                    w_ld   = (r_cnt < NW'(s)) ? 4'b0010 : 4'b0001;
                end
                if (r_cnt == NW'(2 * s + 1)) begin
                    w_next     = ST_RUN;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + NW'(1);
                end
            end
            ST_RUN: begin
                w_fstart = 1'b1;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (fios_done_i) begin
                    w_next     = ST_STORE;
                    w_cnt_next = '0;
                end
            end
            ST_STORE: begin
                w_wr   = 1'b1;
                w_addr = w_base + AW'(2 * s) + AW'(r_cnt);
                if (r_cnt == NW'(s - 1)) begin
                    w_next     = ST_NEXT;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + NW'(1);
                end
            end
            ST_NEXT: begin
                if (CW'(r_slot) + CW'(1) == r_count) begin
                    w_next = ST_DONE;
                end else begin
                    w_slot_next = r_slot + SW'(1);
                    w_next      = ST_LOAD_OPS;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_slot_next = '0;
                w_next      = ST_IDLE;
            end
            ST_ERR: begin
                w_done      = 1'b1;
                w_err       = 1'b1;
                w_slot_next = '0;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // Abort overrides everything, including reads already in the enable pipeline.
        if (w_abort) begin
            w_next    = ST_ERR;
            w_key_clr = 1'b1;
            w_key_set = 1'b0;
            w_rd      = 1'b0;
            w_wr      = 1'b0;
            w_ld      = 4'b0000;
            w_addr    = '0;
            w_fstart  = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_slot      <= '0;
            r_count     <= '0;
            r_key_valid <= 1'b0;
            r_ld0       <= '0;
            r_ld1       <= '0;
            r_ld_o      <= '0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_fstart    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_slot   <= w_slot_next;
            r_count  <= w_count_next;
            if (w_key_clr) begin
                r_key_valid <= 1'b0;
            end else if (w_key_set) begin
                r_key_valid <= 1'b1;
            end
            // Address is registered once; the matching load enable trails it by two more stages.
            r_ld0    <= w_ld;
            r_ld1    <= w_abort ? 4'b0000 : r_ld0;
            r_ld_o   <= w_abort ? 4'b0000 : r_ld1;
            r_en     <= w_rd | w_wr;
            r_we     <= w_wr;
            r_addr   <= w_addr;
            r_fstart <= w_fstart;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    assign pp0_en_o       = r_ld_o[3];
    assign p_en_o         = r_ld_o[2];
    assign a_en_o         = r_ld_o[1];
    assign b_en_o         = r_ld_o[0];
    assign fios_start_o   = r_fstart;
    assign bram.bram_en   = r_en;
    assign bram.bram_we   = r_we;
    assign bram.bram_addr = r_addr;
    assign slot_o         = r_slot;
    assign key_valid_o    = r_key_valid;
    assign busy_o         = (r_state != ST_IDLE);
    assign done_o         = r_done;
    assign err_o          = r_err;
endmodule

// File: tb/tb_mm_batch_control.sv
// Directed bench for mm_batch_control: a table of batch scenarios plus reset and idle-abort sequences.
module tb_mm_batch_control;
    localparam int S     = 8;
    localparam int SLOTS = 4;
    localparam int AW    = 32;
    localparam int FD    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [2:0] slot_count_i = '0;
    logic       reuse_key_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       fios_done_i = 1'b0;
    logic       pp0_en_o, p_en_o, a_en_o, b_en_o, fios_start_o;
    logic [1:0] slot_o;
    logic       key_valid_o, busy_o, done_o, err_o;

    mm_batch_control_if #(.AW(AW)) bif ();

    mm_batch_control #(.W(17), .s(S), .SLOTS(SLOTS), .AW(AW)) dut (
        .clock_i(clk), .reset_i(rst_n), .start_i(start_i), .slot_count_i(slot_count_i),
        .reuse_key_i(reuse_key_i), .abort_i(abort_i), .fios_done_i(fios_done_i),
        .pp0_en_o(pp0_en_o), .p_en_o(p_en_o), .a_en_o(a_en_o), .b_en_o(b_en_o),
        .fios_start_o(fios_start_o), .bram(bif), .slot_o(slot_o),
        .key_valid_o(key_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor state
    int unsigned rd_q[$];
    int unsigned wr_q[$];
    int          done_cnt, done_cyc, fstart_cnt, align_err, slot_bad;
    logic        done_err;
    logic        h_rd1 = 1'b0, h_rd2 = 1'b0;
    int unsigned h_addr1 = 0, h_addr2 = 0;

    function automatic logic [3:0] kind_of(input int unsigned a);
        int unsigned off;
        if (a == 0) return 4'b1000;
        if (a <= S) return 4'b0100;
        off = (a - 1 - S) % (3 * S);
        if (off < S) return 4'b0010;
        if (off < 2 * S) return 4'b0001;
        return 4'b0000;
    endfunction

    always @(negedge clk) begin
        logic [3:0] lds;
        logic       cur_rd;
        lds    = {pp0_en_o, p_en_o, a_en_o, b_en_o};
        cur_rd = bif.bram_en && !bif.bram_we;
        if (lds != 4'b0000) begin
            if (!h_rd2 || lds != kind_of(h_addr2)) align_err++;
        end else if (h_rd2) begin
            align_err++;
        end
        if (cur_rd) rd_q.push_back(bif.bram_addr);
        if (bif.bram_en && bif.bram_we) begin
            wr_q.push_back(bif.bram_addr);
            if (int'(slot_o) != int'((bif.bram_addr - 1 - S) / (3 * S))) slot_bad++;
        end
        if (fios_start_o) fstart_cnt++;
        if (done_o) begin
            done_cnt++;
            done_err = err_o;
            done_cyc = cyc;
        end
        h_rd2   = h_rd1;
        h_addr2 = h_addr1;
        h_rd1   = cur_rd;
        h_addr1 = bif.bram_addr;
    end

    // FIOS core stand-in: done pulse FD cycles after start, plus bench-injected pulses.
    logic fios_auto = 1'b1;
    logic inj_done = 1'b0;
    int   fd_cnt = 0;
    always @(negedge clk) begin
        logic auto_p;
        auto_p = 1'b0;
        if (fios_start_o && fios_auto) fd_cnt = FD + 1;
        if (fd_cnt != 0) begin
            fd_cnt--;
            if (fd_cnt == 0) auto_p = 1'b1;
        end
        fios_done_i = auto_p | inj_done;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int first_diff(input int unsigned a[$], input int unsigned b[$]);
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] != b[i]) return i;
        return -1;
    endfunction

    task automatic clear_mon();
        rd_q.delete();
        wr_q.delete();
        done_cnt = 0; done_cyc = 0; fstart_cnt = 0; align_err = 0; slot_bad = 0;
        done_err = 1'b0;
    endtask

    typedef struct {
        int count;
        bit reuse;
        bit abort_ws;   // abort_i together with start_i (start must win)
        int abort_slot; // abort during WAIT of this slot, -1 = none
        bit glitch;     // stray start_i and fios_done_i during LOAD_OPS
        bit exp_err;
        bit exp_key;
    } vec_t;

    vec_t tbl[7];
    bit   key_model = 1'b0;

    task automatic run_vec(input int i);
        vec_t        v;
        bit          to_err, load_key, got;
        int          nrd, nwr, c0, ca;
        int unsigned exp_rd[$];
        int unsigned exp_wr[$];
        int unsigned b;
        v        = tbl[i];
        ca       = -1;
        to_err   = (v.count == 0) || (v.count > SLOTS);
        load_key = !to_err && !(v.reuse && key_model);
        if (to_err) begin
            nrd = 0; nwr = 0;
        end else if (v.abort_slot >= 0) begin
            nrd = v.abort_slot + 1; nwr = v.abort_slot;
        end else begin
            nrd = v.count; nwr = v.count;
        end
        if (load_key) for (int a = 0; a <= S; a++) exp_rd.push_back(a);
        for (int k = 0; k < nrd; k++) begin
            b = 1 + S + 3 * S * k;
            for (int j = 0; j < 2 * S; j++) exp_rd.push_back(b + j);
        end
        for (int k = 0; k < nwr; k++) begin
            b = 1 + S + 3 * S * k;
            for (int j = 0; j < S; j++) exp_wr.push_back(b + 2 * S + j);
        end
        clear_mon();
        start_i      = 1'b1;
        slot_count_i = 3'(v.count);
        reuse_key_i  = v.reuse;
        abort_i      = v.abort_ws;
        c0           = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        got     = 1'b0;
        for (int k = 1; k < 3000 && !got; k++) begin
            start_i  = v.glitch && (k == 3);
            inj_done = v.glitch && (k == 5);
            if (v.abort_slot >= 0 && ca < 0 && fstart_cnt == v.abort_slot + 1) begin
                abort_i = 1'b1;
                ca      = cyc;
            end else begin
                abort_i = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cnt != 0) got = 1'b1;
        end
        start_i = 1'b0; inj_done = 1'b0; abort_i = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk($sformatf("v%0d done_pulses", i), done_cnt, 1);
        chk($sformatf("v%0d err", i), int'(done_err), int'(v.exp_err));
        chk($sformatf("v%0d key_valid", i), int'(key_valid_o), int'(v.exp_key));
        chk($sformatf("v%0d busy_after", i), int'(busy_o), 0);
        chk($sformatf("v%0d n_reads", i), rd_q.size(), exp_rd.size());
        chk($sformatf("v%0d read_diff_idx", i), first_diff(rd_q, exp_rd), -1);
        chk($sformatf("v%0d n_writes", i), wr_q.size(), exp_wr.size());
        chk($sformatf("v%0d write_diff_idx", i), first_diff(wr_q, exp_wr), -1);
        chk($sformatf("v%0d en_align_errs", i), align_err, 0);
        chk($sformatf("v%0d write_slot_errs", i), slot_bad, 0);
        chk($sformatf("v%0d fios_starts", i), fstart_cnt, (v.abort_slot >= 0) ? v.abort_slot + 1 : nrd);
        if (to_err) chk($sformatf("v%0d err_latency", i), done_cyc - c0, 2);
        if (ca >= 0) chk($sformatf("v%0d abort_latency", i), done_cyc - ca, 2);
        key_model = v.exp_key;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_at_rst;
        bit seen;
        //          count reuse abws aslot glitch err key
        tbl[0] = '{1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{3, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{0, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{5, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{2, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{2, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1};

        #22;
        chk("reset_outputs",
            int'({pp0_en_o, p_en_o, a_en_o, b_en_o, fios_start_o, bif.bram_en, bif.bram_we,
                  (bif.bram_addr != 0), slot_o, key_valid_o, busy_o, done_o, err_o}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // abort_i in IDLE is ignored
        clear_mon();
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("idle_abort_done", done_cnt, 0);
        chk("idle_abort_busy", int'(busy_o), 0);
        chk("idle_abort_key", int'(key_valid_o), int'(key_model));

        // asynchronous reset in the middle of STORE
        clear_mon();
        start_i = 1'b1; slot_count_i = 3'd1; reuse_key_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(posedge clk); #1;
            if (bif.bram_we) seen = 1'b1;
        end
        chk("rst_reached_store", int'(seen), 1);
        #3 rst_n = 1'b0;
        #1;
        wr_at_rst = wr_q.size();
        chk("rst_async_outputs",
            int'({pp0_en_o, p_en_o, a_en_o, b_en_o, fios_start_o, bif.bram_en, bif.bram_we,
                  (bif.bram_addr != 0), slot_o, busy_o, done_o, err_o}), 0);
        chk("rst_async_key", int'(key_valid_o), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("rst_idle_busy", int'(busy_o), 0);
        chk("rst_no_more_writes", wr_q.size(), wr_at_rst);
        chk("rst_no_done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
